// File: rtl/hash_table_pkg.sv
// Shared types and the bucket-index hash for the key tracking table.
// Keys up to 128 bits are folded down to an index of up to 32 bits.
package hash_table_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_DUP  = 2'd1,
        ST_FULL = 2'd2,
        ST_MISS = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CMP,
        S_WR,
        S_RSP
    } state_e;

    // XOR of index_w-bit slices; zero padding above the key adds nothing
    function automatic logic [31:0] hash_fold(input logic [127:0] key,
                                              input int index_w);
        logic [31:0] h;
        h = '0;
        for (int i = 0; i < 128; i++) begin
            h = h ^ ((32'(key >> i) & 32'd1) << (i % index_w));
        end
        return h;
    endfunction

endpackage

// File: rtl/hash_bucket_ram.sv
// Simple dual-port bucket store: registered read, synchronous write.
// Contents are undefined until the controller's clear sweep has run.
module hash_bucket_ram #(
    parameter int AW = 8,
    parameter int DW = 132
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/hash_table_ctrl.sv
// Set-associative key table controller: lookup/insert/delete with
// duplicate/full detection, occupancy count and one-shot responses.
module hash_table_ctrl
    import hash_table_pkg::*;
#(
    parameter int KEY_W   = 32,
    parameter int INDEX_W = 8,
    parameter int WAYS    = 4,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int ENT_W  = $clog2(WAYS * (2**INDEX_W) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [KEY_W-1:0] cmd_key_i,
    output logic             rsp_valid_o,
    output logic             rsp_found_o,
    output logic [WAY_W-1:0] rsp_way_o,
    output logic [1:0]       rsp_status_o,
    output logic [ENT_W-1:0] entries_o,
    output logic             init_done_o
);

    localparam int SLOT_W = KEY_W + 1;
    localparam int DW     = WAYS * SLOT_W;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] init_idx_q, idx_q, cmd_idx;
    op_e                op_q;
    logic [KEY_W-1:0]   key_q;
    logic [127:0]       key_ext;
    logic               accept;

    logic [DW-1:0]      rd_data, wr_data_q, wr_data_d;
    logic [DW-1:0]      ins_data, del_data, ram_wdata;
    logic [INDEX_W-1:0] ram_waddr;
    logic               ram_we;

    logic               hit, has_free;
    logic [WAY_W-1:0]   hit_way, free_way;

    logic               res_found_q, res_found_d;
    logic [WAY_W-1:0]   res_way_q, res_way_d;
    status_e            res_status_q, res_status_d;

    assign cmd_ready_o = (state_q == S_IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;

    always_comb begin
        key_ext = '0;
        key_ext[KEY_W-1:0] = cmd_key_i;
        cmd_idx = INDEX_W'(hash_fold(key_ext, INDEX_W));
    end

    hash_bucket_ram #(
        .AW (INDEX_W),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .re    (accept),
        .raddr (cmd_idx),
        .rdata (rd_data),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    // Scan high to low so the lowest matching / empty way wins
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_data[w*SLOT_W+KEY_W] &&
                rd_data[w*SLOT_W +: KEY_W] == key_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!rd_data[w*SLOT_W+KEY_W]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        ins_data = rd_data;
        del_data = rd_data;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == free_way)
                ins_data[w*SLOT_W +: SLOT_W] = {1'b1, key_q};
            if (WAY_W'(w) == hit_way)
                del_data[w*SLOT_W+KEY_W] = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_data_d    = wr_data_q;
        res_found_d  = res_found_q;
        res_way_d    = res_way_q;
        res_status_d = res_status_q;
        unique case (state_q)
            S_INIT: if (init_idx_q == '1) state_d = S_IDLE;
            S_IDLE: if (cmd_valid_i) state_d = S_CMP;
            S_CMP: begin
                state_d      = S_RSP;
                res_found_d  = 1'b0;
                res_way_d    = '0;
                res_status_d = ST_MISS;
                unique case (op_q)
                    OP_LOOKUP: begin
                        res_found_d  = hit;
                        res_way_d    = hit ? hit_way : '0;
                        res_status_d = hit ? ST_OK : ST_MISS;
                    end
                    OP_INSERT: begin
                        if (hit) begin
                            res_found_d  = 1'b1;
                            res_way_d    = hit_way;
                            res_status_d = ST_DUP;
                        end else if (has_free) begin
                            res_way_d    = free_way;
                            res_status_d = ST_OK;
                            wr_data_d    = ins_data;
                            state_d      = S_WR;
                        end else begin
                            res_status_d = ST_FULL;
                        end
                    end
                    OP_DELETE: begin
                        if (hit) begin
                            res_found_d  = 1'b1;
                            res_way_d    = hit_way;
                            res_status_d = ST_OK;
                            wr_data_d    = del_data;
                            state_d      = S_WR;
                        end
                    end
                    default: ;
                endcase
            end
            S_WR:    state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = idx_q;
        ram_wdata = wr_data_q;
        unique case (1'b1)
            (state_q == S_INIT): begin
                ram_we    = 1'b1;
                ram_waddr = init_idx_q;
                ram_wdata = '0;
            end
            (state_q == S_WR): ram_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_INIT;
            init_idx_q   <= '0;
            init_done_o  <= 1'b0;
            entries_o    <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_found_o  <= 1'b0;
            rsp_way_o    <= '0;
            rsp_status_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) begin
                init_idx_q <= init_idx_q + INDEX_W'(1);
                if (state_d == S_IDLE) init_done_o <= 1'b1;
            end
            // WR is only entered for a successful insert or delete
            if (state_q == S_WR) begin
                entries_o <= (op_q == OP_INSERT) ? entries_o + ENT_W'(1)
                                                 : entries_o - ENT_W'(1);
            end
            rsp_valid_o  <= (state_d == S_RSP);
            rsp_found_o  <= (state_d == S_RSP) && res_found_d;
            rsp_way_o    <= (state_d == S_RSP) ? res_way_d : '0;
            rsp_status_o <= (state_d == S_RSP) ? res_status_d : ST_OK;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_e'(cmd_op_i);
            key_q <= cmd_key_i;
            idx_q <= cmd_idx;
        end
        wr_data_q    <= wr_data_d;
        res_found_q  <= res_found_d;
        res_way_q    <= res_way_d;
        res_status_q <= res_status_d;
    end

endmodule

// File: tb/tb_hash_table_ctrl.sv
// Bench for hash_table_ctrl: directed scenarios then random traffic,
// each response compared with a bucket/way reference model.
module tb_hash_table_ctrl;

    localparam int KEY_W   = 32;
    localparam int INDEX_W = 4;
    localparam int WAYS    = 2;
    localparam int NB      = 16;

    logic             clk;
    logic             rst;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_op_i;
    logic [KEY_W-1:0] cmd_key_i;
    logic             rsp_valid_o;
    logic             rsp_found_o;
    logic [0:0]       rsp_way_o;
    logic [1:0]       rsp_status_o;
    logic [5:0]       entries_o;
    logic             init_done_o;

    int checks = 0;
    int errors = 0;

    bit          mv [NB][WAYS];
    logic [31:0] mk [NB][WAYS];
    int          cnt;

    hash_table_ctrl #(
        .KEY_W   (KEY_W),
        .INDEX_W (INDEX_W),
        .WAYS    (WAYS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_key_i    (cmd_key_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_found_o  (rsp_found_o),
        .rsp_way_o    (rsp_way_o),
        .rsp_status_o (rsp_status_o),
        .entries_o    (entries_o),
        .init_done_o  (init_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bucket_of(input logic [31:0] k);
        int b = 0;
        for (int i = 0; i < 8; i++) b = b ^ int'((k >> (4 * i)) & 32'hF);
        return b;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < WAYS; w++) mv[b][w] = 1'b0;
        cnt = 0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!cmd_ready_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_init_cycles"}, n, 16);
        chk({tag, "_init_done"}, init_done_o, 1);
        chk({tag, "_entries0"}, entries_o, 0);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input logic [31:0] key);
        int b, hw, fw, e_lat, e_way, e_st, n, lat;
        logic e_found;
        b  = bucket_of(key);
        hw = -1;
        fw = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (mv[b][w] && mk[b][w] == key && hw < 0) hw = w;
            if (!mv[b][w] && fw < 0) fw = w;
        end
        e_found = 1'b0; e_way = 0; e_st = 3; e_lat = 2;
        case (op)
            2'd0: if (hw >= 0) begin
                e_found = 1'b1; e_way = hw; e_st = 0;
            end
            2'd1: if (hw >= 0) begin
                e_found = 1'b1; e_way = hw; e_st = 1;
            end else if (fw >= 0) begin
                e_way = fw; e_st = 0; e_lat = 3;
                mv[b][fw] = 1'b1; mk[b][fw] = key; cnt++;
            end else begin
                e_st = 2;
            end
            2'd2: if (hw >= 0) begin
                e_found = 1'b1; e_way = hw; e_st = 0; e_lat = 3;
                mv[b][hw] = 1'b0; cnt--;
            end
            default: ;
        endcase

        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_key_i   = key;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({tag, "_ready_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'($urandom);
        cmd_key_i   = $urandom;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_o) break;
        end
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_found"}, rsp_found_o, e_found);
        chk({tag, "_way"}, rsp_way_o, e_way);
        chk({tag, "_status"}, rsp_status_o, e_st);
        chk({tag, "_entries"}, entries_o, cnt);
        @(negedge clk);
        chk({tag, "_rsp_one_shot"}, rsp_valid_o, 0);
    endtask

    initial begin
        bit saw;
        int n;
        rst         = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'd0;
        cmd_key_i   = '0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_entries", entries_o, 0);
        chk("rst_init_done", init_done_o, 0);
        rst = 1'b1;
        wait_init("boot");

        run_cmd("ins_1", 2'd1, 32'h1);
        run_cmd("look_1", 2'd0, 32'h1);
        run_cmd("ins_10", 2'd1, 32'h10);
        run_cmd("ins_100_full", 2'd1, 32'h100);
        run_cmd("ins_10_dup", 2'd1, 32'h10);
        run_cmd("del_1", 2'd2, 32'h1);
        run_cmd("look_1_miss", 2'd0, 32'h1);
        run_cmd("ins_100_reuse", 2'd1, 32'h100);
        run_cmd("del_absent", 2'd2, 32'hDEAD);
        run_cmd("bad_op", 2'd3, 32'h10);
        run_cmd("look_10_after_bad", 2'd0, 32'h10);

        // Reset while an insert is in its write cycle
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'd1;
        cmd_key_i   = 32'h5;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid_o) saw = 1'b1;
        end
        chk("midrst_no_rsp", saw, 0);
        chk("midrst_entries", entries_o, 0);
        chk("midrst_init_done", init_done_o, 0);
        model_clear();
        rst = 1'b1;
        wait_init("midrst");
        run_cmd("midrst_look_5", 2'd0, 32'h5);
        run_cmd("midrst_look_10", 2'd0, 32'h10);

        for (int i = 0; i < 300; i++) begin
            int r;
            logic [1:0] op;
            r  = $urandom_range(0, 9);
            op = (r < 3) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            run_cmd($sformatf("rnd%0d", i), op, 32'($urandom_range(0, 63)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
